uart_tx_arbiter: RTL

Shares one multi-byte UART transmitter among NREQ requesters. Each requester presents a payload of up to 8 bytes. The arbiter grants one request at a time, forwards the payload with a launch pulse, and tracks the transmitter busy flag to completion. It then reports completion to the owner. It sits between system-side message sources (status reporters, debug dumpers) and the single UART TX pin path.

---
 rtl/uart_arb_pkg.sv | 24 ++
 rtl/uart_tx_arbiter_if.sv | 25 ++
 rtl/uart_arb_pick.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// uart_tx_arbiter shared types: FSM states, payload limit, length clamp.
// Optional build macro: UART_ARB_RR_EN (round-robin arbitration).
package uart_arb_pkg;

  localparam int MAX_BYTES = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_DONE
  } arb_state_e;

  function automatic logic [3:0] clamp_len(
    input logic [3:0] len
  );
    if (len > 4'(MAX_BYTES)) begin
      return 4'(MAX_BYTES);
    end
    return len;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Transmitter-side bundle: latched payload, launch strobe, busy flag.
// Arbiter drives it through master, the UART TX through slave.
interface uart_tx_arbiter_if;
  import uart_arb_pkg::*;

  logic [8*MAX_BYTES-1:0] tx_bytes;
  logic [3:0]             tx_len;
  logic                   tx_pulse;
  logic                   tx_busy;

  modport master (
    output tx_bytes,
    output tx_len,
    output tx_pulse,
    input  tx_busy
  );

  modport slave (
    input  tx_bytes,
    input  tx_len,
    input  tx_pulse,
    output tx_busy
  );

endinterface

// File: rtl/uart_arb_pick.sv
// Combinational winner select: first set request at or after ptr.
// Fixed-priority builds tie ptr to zero, giving lowest-index-wins.
module uart_arb_pick #(
  parameter int NREQ = 4,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic            valid,
  output logic [IDXW-1:0] idx
);

  always_comb begin
    int j;
    logic [IDXW-1:0] k;
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    k     = '0;
    // walk from the far end so the nearest offset wins last
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= NREQ) begin
        j = j - NREQ;
      end
      k = j[IDXW-1:0];
      if (req[k]) begin
        valid = 1'b1;
        idx   = k;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one multi-byte UART transmitter among NREQ requesters.
// Optional build macro: UART_ARB_RR_EN (round-robin, else fixed priority).
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NREQ-1:0]    req,
  input  logic [64*NREQ-1:0] req_data,
  input  logic [4*NREQ-1:0]  req_len,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic               arb_busy,
  uart_tx_arbiter_if.master  tx
);

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [63:0]     tx_bytes_q, tx_bytes_d;
  logic [3:0]      tx_len_q, tx_len_d;
  logic            tx_pulse_q, tx_pulse_d;
  logic            arb_busy_q, arb_busy_d;
  logic [IDXW-1:0] owner_q, owner_d;
  logic            busy_q, busy_d;

  logic [IDXW-1:0] ptr;
  logic            pick_valid;
  logic [IDXW-1:0] pick_idx;
  logic [63:0]     sel_data;
  logic [3:0]      sel_len;

`ifdef UART_ARB_RR_EN
  logic [IDXW-1:0] ptr_q, ptr_d;

  assign ptr = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_DONE) begin
      ptr_d = (owner_q == IDXW'(NREQ - 1)) ? '0 : owner_q + IDXW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign ptr = '0;
`endif

  uart_arb_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    sel_data = '0;
    sel_len  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == IDXW'(i)) begin
        sel_data = req_data[64*i +: 64];
        sel_len  = req_len[4*i +: 4];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = '0;
    done_d     = '0;
    tx_pulse_d = 1'b0;
    tx_bytes_d = tx_bytes_q;
    tx_len_d   = tx_len_q;
    arb_busy_d = arb_busy_q;
    owner_d    = owner_q;
    busy_d     = tx.tx_busy;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          owner_d         = pick_idx;
          tx_bytes_d      = sel_data;
          tx_len_d        = clamp_len(sel_len);
          gnt_d[pick_idx] = 1'b1;
          arb_busy_d      = 1'b1;
          state_d = (sel_len == 4'd0) ? ST_DONE : ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        tx_pulse_d = 1'b1;
        state_d    = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (tx.tx_busy) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        // busy_q holds last cycle's flag: 1 then 0 is the fall
        if (busy_q && !tx.tx_busy) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_d[owner_q] = 1'b1;
        arb_busy_d      = 1'b0;
        state_d         = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      done_q     <= '0;
      tx_bytes_q <= '0;
      tx_len_q   <= '0;
      tx_pulse_q <= 1'b0;
      arb_busy_q <= 1'b0;
      owner_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      tx_bytes_q <= tx_bytes_d;
      tx_len_q   <= tx_len_d;
      tx_pulse_q <= tx_pulse_d;
      arb_busy_q <= arb_busy_d;
      owner_q    <= owner_d;
      busy_q     <= busy_d;
    end
  end

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign arb_busy    = arb_busy_q;
  assign tx.tx_bytes = tx_bytes_q;
  assign tx.tx_len   = tx_len_q;
  assign tx.tx_pulse = tx_pulse_q;

endmodule
